// File: rtl/pwc_pkg.sv
// Shared types and defaults for the pulse-width capture block.
// State codes are fixed constants so the encoding stays stable across netlists.
package pwc_pkg;

   localparam int PWC_DEFAULT_WIDTH = 32;

   localparam logic [1:0] PWC_S_IDLE    = 2'd0;
   localparam logic [1:0] PWC_S_ARMED   = 2'd1;
   localparam logic [1:0] PWC_S_MEASURE = 2'd2;
   localparam logic [1:0] PWC_S_DONE    = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = PWC_S_IDLE,
      ARMED   = PWC_S_ARMED,
      MEASURE = PWC_S_MEASURE,
      DONE    = PWC_S_DONE
   } pwc_state_e;

endpackage

// File: rtl/pulse_width_capture_sat_counter.sv
// Saturating up-counter: load starts at 1, inc stops at all-ones and raises a
// sticky sat_flag for any increment attempted at the maximum.
module sat_counter
   import pwc_pkg::*;
#(
   parameter int WIDTH = PWC_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             sat_flag
);

   always_ff @(posedge clk) begin
      if (clr) begin
         count    <= '0;
         sat_flag <= 1'b0;
      end else if (load) begin
         count    <= WIDTH'(1);
         sat_flag <= 1'b0;
      end else if (inc) begin
         if (&count) begin
            sat_flag <= 1'b1;
         end else begin
            count <= count + WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/pulse_width_capture.sv
// Counts the cycles sig_in spends at its active level and returns the result
// through a valid/ready port; the edge cycle itself counts as cycle one.
//
//   state   | meaning
//   IDLE    | waiting for arm
//   ARMED   | waiting for a fresh active edge
//   MEASURE | counting active cycles
//   DONE    | result held until meas_ready
module pulse_width_capture
   import pwc_pkg::*;
#(
   parameter int WIDTH       = PWC_DEFAULT_WIDTH,
   parameter bit ACTIVE_HIGH = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             arm,
   input  logic             clear,
   input  logic             sig_in,
   output logic             busy,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic [WIDTH-1:0] meas_count,
   output logic             meas_overflow
);

   pwc_state_e       state_q;
   pwc_state_e       state_d;
   logic             act;
   logic             act_prev;
   logic             rise;
   logic             cnt_clr;
   logic             cnt_load;
   logic             cnt_inc;
   logic [WIDTH-1:0] cnt_value;
   logic             cnt_sat;

   assign act  = ACTIVE_HIGH ? sig_in : ~sig_in;
   assign rise = act & ~act_prev;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (arm)  state_d = ARMED;
         ARMED:   if (rise) state_d = MEASURE;
         MEASURE: if (!act) state_d = DONE;
         DONE:    if (meas_ready) state_d = arm ? ARMED : IDLE;
         default: state_d = IDLE;
      endcase
      if (clear) state_d = IDLE;
   end

   assign cnt_clr  = rst | clear;
   assign cnt_load = (state_q == ARMED) & rise;
   assign cnt_inc  = (state_q == MEASURE) & act;

   sat_counter #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clk      (clk),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .inc      (cnt_inc),
      .count    (cnt_value),
      .sat_flag (cnt_sat)
   );

   // act_prev resets to the inactive level so a level already active at
   // reset release is not mistaken for an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         act_prev      <= 1'b0;
         meas_count    <= '0;
         meas_overflow <= 1'b0;
      end else begin
         state_q  <= state_d;
         act_prev <= act;
         if (clear) begin
            meas_count    <= '0;
            meas_overflow <= 1'b0;
         end else if ((state_q == MEASURE) && !act) begin
            meas_count    <= cnt_value;
            meas_overflow <= cnt_sat;
         end
      end
   end

   assign busy       = (state_q == ARMED) | (state_q == MEASURE);
   assign meas_valid = (state_q == DONE);

endmodule

// File: tb/tb_pulse_width_capture.sv
// Scoreboard bench: three builds (32-bit high, 32-bit low, 4-bit high) watch
// the same logical pulse train; expectations come from the pulse widths.
module tb_pulse_width_capture;

   logic clk = 1'b0;
   logic rst, arm, clear, meas_ready, act, sig_lo;
   logic       bsy [3];
   logic       vld [3];
   logic       ovf [3];
   logic [31:0] cnt [3];
   logic [31:0] cnt_a, cnt_l;
   logic [3:0]  cnt_s;

   assign sig_lo = ~act;
   assign cnt[0] = cnt_a;
   assign cnt[1] = cnt_l;
   assign cnt[2] = {28'd0, cnt_s};

   always #5 clk = ~clk;

   pulse_width_capture #(.WIDTH(32), .ACTIVE_HIGH(1'b1)) dut_a (
      .clk(clk), .rst(rst), .arm(arm), .clear(clear), .sig_in(act),
      .busy(bsy[0]), .meas_valid(vld[0]), .meas_ready(meas_ready),
      .meas_count(cnt_a), .meas_overflow(ovf[0]));

   pulse_width_capture #(.WIDTH(32), .ACTIVE_HIGH(1'b0)) dut_l (
      .clk(clk), .rst(rst), .arm(arm), .clear(clear), .sig_in(sig_lo),
      .busy(bsy[1]), .meas_valid(vld[1]), .meas_ready(meas_ready),
      .meas_count(cnt_l), .meas_overflow(ovf[1]));

   pulse_width_capture #(.WIDTH(4), .ACTIVE_HIGH(1'b1)) dut_s (
      .clk(clk), .rst(rst), .arm(arm), .clear(clear), .sig_in(act),
      .busy(bsy[2]), .meas_valid(vld[2]), .meas_ready(meas_ready),
      .meas_count(cnt_s), .meas_overflow(ovf[2]));

   typedef struct {
      logic [31:0] count;
      logic        ovf;
      int          rise;
   } exp_t;

   exp_t sb [3][$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic vld_prev [3];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s dut%0d got %0d expected %0d (cycle %0d)", nm, d, got, want, cyc);
      end
   endtask

   // Reference: a pulse of n active cycles reports n (4-bit build saturates at
   // 15 with overflow when n > 15); valid appears the cycle after the fall.
   task automatic push_exp(input int n);
      exp_t e;
      e.rise  = cyc + 1;
      e.count = n;
      e.ovf   = 1'b0;
      sb[0].push_back(e);
      sb[1].push_back(e);
      e.count = (n > 15) ? 15 : n;
      e.ovf   = (n > 15);
      sb[2].push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         for (int d = 0; d < 3; d++) vld_prev[d] = 1'b0;
      end else begin
         for (int d = 0; d < 3; d++) begin
            if (sb[d].size() == 0) begin
               chk("spurious_valid", d, {31'd0, vld[d]}, 32'd0);
            end else if (vld[d]) begin
               if (!vld_prev[d]) chk("valid_latency", d, cyc, sb[d][0].rise);
               chk("meas_count", d, cnt[d], sb[d][0].count);
               chk("meas_overflow", d, {31'd0, ovf[d]}, {31'd0, sb[d][0].ovf});
               if (meas_ready) void'(sb[d].pop_front());
            end
            vld_prev[d] = vld[d];
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int n, input bit expect_capture);
      act = 1'b1;
      repeat (n) step();
      act = 1'b0;
      if (expect_capture) push_exp(n);
      step();
   endtask

   task automatic do_arm();
      step();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   task automatic capture(input int n);
      do_arm();
      repeat ($urandom_range(0, 3)) step();
      pulse(n, 1'b1);
      repeat ($urandom_range(1, 3)) step();
   endtask

   task automatic check_quiet(input string nm);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk({nm, "_busy"}, d, {31'd0, bsy[d]}, 32'd0);
         chk({nm, "_valid"}, d, {31'd0, vld[d]}, 32'd0);
         chk({nm, "_count"}, d, cnt[d], 32'd0);
         chk({nm, "_ovf"}, d, {31'd0, ovf[d]}, 32'd0);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; arm = 1'b0; clear = 1'b0; meas_ready = 1'b1; act = 1'b0;
      step();
      check_quiet("reset");
      step();
      rst = 1'b0;

      // Activity without arm must never produce a result.
      for (int i = 0; i < 20; i++) begin
         act = 1'($urandom_range(0, 1));
         step();
         if (i % 5 == 4) check_quiet("idle");
      end
      act = 1'b0;
      repeat (3) step();

      capture(1);
      capture(5);
      capture(1000);

      // Already active at arm: only a fresh edge may start a capture.
      meas_ready = 1'b0;
      act = 1'b1;
      repeat (2) step();
      do_arm();
      repeat (3) step();
      act = 1'b0;
      repeat (2) step();
      pulse(7, 1'b1);
      repeat (2) step();
      for (int k = 0; k < 3; k++) begin
         pulse($urandom_range(1, 4), 1'b0);
         step();
      end
      do_arm();
      @(negedge clk);
      for (int d = 0; d < 3; d++) chk("held_valid", d, {31'd0, vld[d]}, 32'd1);

      // Accept and re-arm in the same cycle, then capture immediately.
      step();
      meas_ready = 1'b1;
      arm = 1'b1;
      step();
      arm = 1'b0;
      pulse(12, 1'b1);
      repeat (3) step();

      capture(9);
      capture(20);
      capture(3);
      capture(15);
      capture(16);

      // Abort mid-measurement.
      do_arm();
      act = 1'b1;
      repeat (4) step();
      @(negedge clk);
      for (int d = 0; d < 3; d++) chk("busy_measure", d, {31'd0, bsy[d]}, 32'd1);
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      act = 1'b0;
      check_quiet("clear");
      repeat (2) step();

      // Timer loop-back: a timer set to i holds the line active for i cycles.
      for (int i = 1; i <= 200; i++) capture(i);

      for (int i = 0; i < 30; i++) capture($urandom_range(1, 40));

      for (int t = 0; t < 50; t++) begin
         if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0) break;
         step();
      end
      for (int d = 0; d < 3; d++) chk("drain", d, sb[d].size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_width_capture.md
Name: pulse_width_capture

Overview:
- Measures how many clock cycles an input signal stays in its active level, then presents the count on a valid/ready output port.
- It is the measuring counterpart of digitalTimer: digitalTimer generates an event N cycles after it is loaded; this block observes an event and reports N.
- Sits beside digitalTimer on the peripheral side. Loop-back of timer-driven pulses through this block must reproduce the programmed value exactly.

Parameters:
- WIDTH, 32, bit width of the cycle counter and the meas_count output.
- ACTIVE_HIGH, 1, 1 = measure the high time of sig_in; 0 = measure the low time (sig_in is inverted internally before edge detection).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- arm  input  1  single-cycle request to begin waiting for the next active edge.
- clear  input  1  synchronous abort. Returns the block to IDLE from any state.
- sig_in  input  1  signal under measurement; already synchronous to clk.
- busy  output  1  high in ARMED and MEASURE.
- meas_valid  output  1  result available; high only in DONE.
- meas_ready  input  1  consumer accepts the result.
- meas_count  output  WIDTH  measured active cycles; stable while meas_valid=1.
- meas_overflow  output  1  count saturated; qualified by meas_valid.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; busy=0, meas_valid=0, meas_count=0, meas_overflow=0.
  - The edge-history register is set to the inactive level, so no false edge is detected after reset.
- Active level: a = ACTIVE_HIGH ? sig_in : ~sig_in. Rising active edge = a & ~a_prev. a_prev is registered every cycle in every state.
- State IDLE:
  - arm=1 -> ARMED next cycle.
  - An edge in the same cycle as arm is not captured.
- State ARMED:
  - Waits for an active edge. If a is already 1 when arming, the block waits for a fresh edge.
  - On the edge -> MEASURE, counter loaded with 1 (the edge cycle counts).
  - arm is ignored.
- State MEASURE:
  - Each cycle with a=1: counter += 1, saturating at 2^WIDTH-1.
  - An increment attempted at the maximum sets the overflow flag; the counter holds.
  - First cycle with a=0 -> DONE. meas_count/meas_overflow are registered on that edge.
  - arm is ignored.
- Latency: an active pulse of N sampled cycles (samples t..t+N-1, inactive at t+N) gives meas_valid=1 and meas_count=N during cycle t+N+1.
- State DONE:
  - meas_valid=1; meas_count and meas_overflow are held constant.
  - Further sig_in activity is ignored (no second capture, no buffering).
  - meas_valid & meas_ready -> IDLE; outputs keep their last value but meas_valid=0.
  - meas_valid & meas_ready & arm in the same cycle -> ARMED directly (back-to-back capture).
  - arm without meas_ready is ignored.
- clear:
  - Any state -> IDLE next cycle; meas_valid=0; counter, meas_count and meas_overflow cleared to 0.
  - Priority: clear over arm and over the handshake.
  - rst has priority over everything.
- Minimum pulse: N=1 (single-cycle active) reports 1.
- Saturation example: WIDTH=4, pulse of 20 cycles -> meas_count=15, meas_overflow=1.
- No combinational path from any input to any output.

Decomposition:
- Shared package pwc_pkg:
  - state typedef enum {IDLE, ARMED, MEASURE, DONE} (2-bit).
  - localparam PWC_DEFAULT_WIDTH=32.
- One natural sub-module: sat_counter.
  - Parameter WIDTH; inputs load, inc, clr.
  - Outputs count and sat_flag.
  - Instantiated once for the measurement counter.

Test Plan:
- Reset then idle: hold rst 2 cycles, toggle sig_in with no arm -> meas_valid never rises, busy=0, meas_count=0.
- Basic widths (WIDTH=32, ACTIVE_HIGH=1): arm, then pulses of 1, 5 and 1000 cycles -> meas_count=1, 5, 1000 respectively, meas_overflow=0, meas_valid exactly 1 cycle after sig_in falls.
- Pre-high and back-pressure: sig_in already high at arm -> no capture until it falls and rises again; then a 7-cycle pulse -> 7. Hold meas_ready=0 for 10 cycles while sig_in pulses 3 more times -> count stays 7, valid stays 1.
- Back-to-back: in DONE assert meas_ready+arm together, then a 12-cycle pulse -> second result 12 with no missed edge; ACTIVE_HIGH=0 build, low pulse of 9 cycles -> 9.
- Saturation (WIDTH=4): arm, 20-cycle pulse -> meas_count=15, meas_overflow=1; next capture of 3 cycles -> 3, overflow=0.
- Abort and loop-back: clear mid-MEASURE (after 4 cycles) -> IDLE next cycle, valid=0, count=0. Drive sig_in from digitalTimer set to i for i=1..200 (timer_is_high rising after i cycles, pulse formed from set_timer to timer_is_high) -> meas_count=i every iteration.
